// File: rtl/stolen_cdc_hsk_src_if.sv
// Handshake bundle for the CDC source controller: upstream valid/ready word
// interface plus the request/data/ack crossing and status signals.
interface stolen_cdc_hsk_src_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             src_req;
    logic [WIDTH-1:0] src_data;
    logic             src_ack;
    logic             done_pulse;
    logic             busy;
    logic             timeout_err;
    logic             timeout_clr;

    modport master (
        input  in_valid, in_data, src_ack, timeout_clr,
        output in_ready, src_req, src_data, done_pulse, busy, timeout_err
    );

    modport slave (
        output in_valid, in_data, src_ack, timeout_clr,
        input  in_ready, src_req, src_data, done_pulse, busy, timeout_err
    );
endinterface

// File: rtl/stolen_cdc_hsk_src.sv
// Source-domain four-phase req/ack controller: latches a word, raises a level
// request, and waits for the synchronised ack to rise and fall again.
module stolen_cdc_hsk_src #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                   src_clk,
    input  logic                   src_rst,
    stolen_cdc_hsk_src_if.master   hsk
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        ACK_LO = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             src_req_q, src_req_d;
    logic [WIDTH-1:0] src_data_q, src_data_d;
    logic             done_q, done_d;
    logic             accept;

    // A stale ack left high by a one-sided reset blocks new requests until it drops.
    assign accept = (state_q == IDLE) && hsk.in_valid && !hsk.src_ack;

    always_comb begin
        state_d    = state_q;
        src_req_d  = src_req_q;
        src_data_d = src_data_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    src_data_d = hsk.in_data;
                    src_req_d  = 1'b1;
                    state_d    = REQ_HI;
                end
            end
            REQ_HI: begin
                if (hsk.src_ack) begin
                    src_req_d = 1'b0;
                    state_d   = ACK_LO;
                end
            end
            ACK_LO: begin
                if (!hsk.src_ack) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                src_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge src_clk or posedge src_rst) begin
        if (src_rst) begin
            state_q    <= IDLE;
            src_req_q  <= 1'b0;
            src_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_req_q  <= src_req_d;
            src_data_q <= src_data_d;
            done_q     <= done_d;
        end
    end

    assign hsk.in_ready   = (state_q == IDLE) && !hsk.src_ack;
    assign hsk.src_req    = src_req_q;
    assign hsk.src_data   = src_data_q;
    assign hsk.done_pulse = done_q;
    assign hsk.busy       = (state_q != IDLE);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            localparam int             CW    = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT_CYCLES);
            localparam logic [CW-1:0]  LAST  = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] cnt_q, cnt_d;
            logic          err_q, err_d;
            logic          hit;

            // Flag fires once on the increment that reaches the limit; the saturated
            // count cannot re-fire it within the same phase after a clear.
            always_comb begin
                cnt_d = cnt_q;
                hit   = 1'b0;
                if (state_d != state_q) begin
                    cnt_d = '0;
                end else if (state_q != IDLE && cnt_q != LIMIT) begin
                    cnt_d = cnt_q + CW'(1);
                    hit   = (cnt_q == LAST);
                end
                err_d = hit | (err_q & ~hsk.timeout_clr);
            end

            always_ff @(posedge src_clk or posedge src_rst) begin
                if (src_rst) begin
                    cnt_q <= '0;
                    err_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    err_q <= err_d;
                end
            end

            assign hsk.timeout_err = err_q;
        end else begin : g_no_wdog
            logic unused_timeout_clr;
            assign unused_timeout_clr = hsk.timeout_clr;
            assign hsk.timeout_err    = 1'b0;
        end
    endgenerate

endmodule

// File: doc/stolen_cdc_hsk_src.md
Name: stolen_cdc_hsk_src

Overview:
Source-domain controller for a four-phase req/ack handshake that moves a multi-bit word across clock domains.
- Accepts a word on a valid/ready interface and holds it stable on src_data.
- Drives a registered level request into a stolen_cdc_single instance (SRC_INPUT_REG=0).
- Consumes the acknowledge after it has been synchronised back into src_clk by a second stolen_cdc_single.
- Sits directly upstream of the request synchroniser. It is the only logic allowed to drive the request level and the crossing data bus.

Parameters:
WIDTH, 32, width of the transferred word (>=1).
TIMEOUT_CYCLES, 0, watchdog limit in src_clk cycles per handshake phase; 0 disables the watchdog.

Ports:
src_clk  input  1  source-domain clock.
src_rst  input  1  asynchronous, active-high reset.
in_valid  input  1  upstream word valid.
in_ready  output  1  block can accept a word this cycle.
in_data  input  WIDTH  upstream word.
src_req  output  1  registered request level; goes to the synchroniser input.
src_data  output  WIDTH  registered crossing data; stable whenever src_req=1 and while waiting for ack low.
src_ack  input  1  acknowledge, already synchronised into src_clk.
done_pulse  output  1  one-cycle pulse when a handshake fully completes.
busy  output  1  handshake in progress (state != IDLE).
timeout_err  output  1  sticky watchdog flag.
timeout_clr  input  1  clears timeout_err.

Behaviour:
- Reset (async assert, sync release):
  - State returns to IDLE.
  - src_req=0, src_data=0, done_pulse=0, timeout_err=0, watchdog counter=0.
  - src_req must fall immediately on reset assertion, not at the next edge.
- FSM states: IDLE, REQ_HI, ACK_LO.
  - IDLE: in_ready = ~src_ack (combinational). On in_valid & in_ready at edge N: src_data<=in_data, src_req<=1, go to REQ_HI. src_req is visible high in cycle N+1.
  - REQ_HI: in_ready=0. When src_ack=1 is sampled: src_req<=0, go to ACK_LO.
  - ACK_LO: in_ready=0, src_req=0, src_data held. When src_ack=0 is sampled: go to IDLE and register done_pulse=1 for exactly the first IDLE cycle.
- The earliest next acceptance is in that same first IDLE cycle, which gives back-to-back transfers.
- Stale ack: if src_ack=1 in IDLE (for example after a one-sided reset), in_ready stays 0 and no request is issued until ack drops.
- src_data changes only on acceptance. It never changes in REQ_HI or ACK_LO.
- src_req, src_data and done_pulse come straight from flops, with no combinational logic after the register.
- busy = (state != IDLE), derived from registered state.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter width is $clog2(TIMEOUT_CYCLES+1). It clears on every state transition and increments each cycle in REQ_HI or ACK_LO, saturating.
  - When it reaches TIMEOUT_CYCLES, timeout_err<=1.
  - The handshake is never aborted: the FSM keeps waiting.
  - timeout_clr clears timeout_err the next cycle. If set and clear occur in the same cycle, set wins.
- Watchdog disabled (TIMEOUT_CYCLES=0): timeout_err is constant 0, no counter logic exists, and timeout_clr is ignored.
- in_valid while not ready: ignored. The upstream holds its word (valid/ready rules apply).
- Reset mid-handshake: the FSM goes to IDLE and src_req drops. Any word in flight is lost and no done_pulse is issued. The stale-ack rule then blocks acceptance until the destination side releases ack.

Test Plan:
- Single transfer, WIDTH=32, ack echoed through a 4-cycle delay:
  - in_data=0xDEADBEEF accepted at edge 0 -> src_req=1 from cycle 1, src_data=0xDEADBEEF.
  - ack rises at cycle 5 -> src_req=0 at cycle 6.
  - ack falls at cycle 10 -> done_pulse=1 only in cycle 11, in_ready=1 in cycle 11.
- Back-to-back, in_valid held high with words 0x1, 0x2, 0x3 -> three done_pulses.
  - src_data takes 0x1, 0x2, 0x3 in order.
  - src_data never changes while src_req=1 or in ACK_LO.
- Stale ack: release reset with src_ack=1 and in_valid=1 -> in_ready=0 and src_req=0 until ack falls; acceptance happens in the first cycle ack=0.
- Watchdog, TIMEOUT_CYCLES=8, ack held low after the request:
  - timeout_err=1 eight cycles after entering REQ_HI, and src_req stays 1.
  - Pulse timeout_clr -> flag clears.
  - Assert timeout_clr in the set cycle -> flag stays 1.
- Reset mid-handshake: assert src_rst asynchronously in REQ_HI -> src_req=0 before the next src_clk edge, busy=0, no done_pulse. After release, the next transfer completes normally.
- TIMEOUT_CYCLES=0 with a 1000-cycle ack stall -> timeout_err stays 0, and the transfer completes when ack arrives.
